// File: rtl/b2tt_trigger_fanout_if.sv
// Bus bundle between the b2tt receiver side and the trigger fan-out block.
// The receiver/controller side uses the master modport; the fan-out uses slave.
interface b2tt_trigger_fanout_if #(
  parameter int CHANNELS       = 4,
  parameter int DELAY_WIDTH    = 8,
  parameter int PULSE_WIDTH    = 4,
  parameter int PRESCALE_WIDTH = 8,
  parameter int COUNT_WIDTH    = 16
);
  logic                               trg;
  logic                               frame9;
  logic [CHANNELS-1:0]                enable;
  logic [CHANNELS*DELAY_WIDTH-1:0]    delay;
  logic [CHANNELS*PULSE_WIDTH-1:0]    width;
  logic [CHANNELS*PRESCALE_WIDTH-1:0] prescale;
  logic                               clear;
  logic [CHANNELS-1:0]                pulse_out;
  logic [CHANNELS-1:0]                busy;
  logic [CHANNELS-1:0]                missed;
  logic [COUNT_WIDTH-1:0]             trigger_count;

  modport master (
    output trg, frame9, enable, delay, width, prescale, clear,
    input  pulse_out, busy, missed, trigger_count
  );

  modport slave (
    input  trg, frame9, enable, delay, width, prescale, clear,
    output pulse_out, busy, missed, trigger_count
  );
endinterface

// File: rtl/b2tt_trigger_fanout.sv
// Trigger fan-out for the b2tt receiver: CHANNELS independent outputs, each
// with its own prescaler, delay and pulse width, plus a sticky missed-trigger
// flag per channel and a wrapping accepted-trigger counter.
// Optional feature macro: B2TT_TRIGGER_FANOUT_FRAME_SYNC_EN -- when defined,
// frame9 re-phases every prescale counter to 0 so prescaled outputs lock to
// the revolution marker.
module b2tt_trigger_fanout #(
  parameter int CHANNELS       = 4,
  parameter int DELAY_WIDTH    = 8,
  parameter int PULSE_WIDTH    = 4,
  parameter int PRESCALE_WIDTH = 8,
  parameter int COUNT_WIDTH    = 16
) (
  input logic                 clock,
  input logic                 reset_n,
  b2tt_trigger_fanout_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } state_t;

  logic [CHANNELS-1:0]    missed_set;
  logic [CHANNELS-1:0]    missed_q;
  logic [COUNT_WIDTH-1:0] count_q;

`ifndef B2TT_TRIGGER_FANOUT_FRAME_SYNC_EN
  logic unused_frame9;
  assign unused_frame9 = bus.frame9;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t                    state_q, state_d;
    logic [DELAY_WIDTH-1:0]    dcnt_q, dcnt_d;
    logic [PULSE_WIDTH-1:0]    wcnt_q, wcnt_d;
    logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d, pcnt_cur;
    logic [DELAY_WIDTH-1:0]    delay_c;
    logic [PULSE_WIDTH-1:0]    width_c;
    logic [PRESCALE_WIDTH-1:0] prescale_c;
    logic                      selected;
    logic                      miss_c;

    assign delay_c    = bus.delay[c*DELAY_WIDTH +: DELAY_WIDTH];
    assign width_c    = bus.width[c*PULSE_WIDTH +: PULSE_WIDTH];
    assign prescale_c = bus.prescale[c*PRESCALE_WIDTH +: PRESCALE_WIDTH];

    // Prescale phase seen by this cycle's trigger, after optional frame alignment
    always_comb begin
`ifdef B2TT_TRIGGER_FANOUT_FRAME_SYNC_EN
      pcnt_cur = bus.frame9 ? '0 : pcnt_q;
`else
      pcnt_cur = pcnt_q;
`endif
    end

    assign selected = bus.enable[c] && bus.trg && (pcnt_cur == '0);

    // Next state, countdown loads and prescale advance for this channel
    always_comb begin
      // NOTE: every output of this block gets a default first so that no
      // path through the case statement leaves a variable unassigned, which
      // would otherwise infer a latch.
      state_d = state_q;
      dcnt_d  = dcnt_q;
      wcnt_d  = wcnt_q;
      pcnt_d  = pcnt_cur;
      miss_c  = 1'b0;

      if (!bus.enable[c]) begin
        state_d = IDLE;
        pcnt_d  = '0;
      end else begin
        // The prescaler advances on every trigger, busy or not.
        if (bus.trg) begin
          pcnt_d = (pcnt_cur == prescale_c) ? '0 : pcnt_cur + PRESCALE_WIDTH'(1);
        end

        unique case (state_q)
          IDLE: begin
            if (selected) begin
              // Width and delay are captured here; later edits to the inputs
              // do not disturb a sequence already running.
              wcnt_d = (width_c == '0) ? '0 : width_c - PULSE_WIDTH'(1);
              if (delay_c == '0) begin
                state_d = PULSE;
              end else begin
                state_d = DELAY;
                dcnt_d  = delay_c - DELAY_WIDTH'(1);
              end
            end
          end
          DELAY: begin
            miss_c = selected;
            if (dcnt_q == '0) state_d = PULSE;
            else              dcnt_d  = dcnt_q - DELAY_WIDTH'(1);
          end
          PULSE: begin
            miss_c = selected;
            if (wcnt_q == '0) state_d = IDLE;
            else              wcnt_d  = wcnt_q - PULSE_WIDTH'(1);
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // Channel state and counters; reset aborts a running pulse at once
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        dcnt_q  <= '0;
        wcnt_q  <= '0;
        pcnt_q  <= '0;
      end else begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every flop samples the pre-edge values of the others.
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        wcnt_q  <= wcnt_d;
        pcnt_q  <= pcnt_d;
      end
    end

    assign bus.pulse_out[c] = (state_q == PULSE);
    assign bus.busy[c]      = (state_q != IDLE);
    assign missed_set[c]    = miss_c;
  end

  // Sticky missed flags and trigger counter; a coincident set beats clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      missed_q <= '0;
      count_q  <= '0;
    end else begin
      missed_q <= (bus.clear ? '0 : missed_q) | missed_set;
      if (bus.clear)    count_q <= bus.trg ? COUNT_WIDTH'(1) : '0;
      else if (bus.trg) count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign bus.missed        = missed_q;
  assign bus.trigger_count = count_q;

endmodule
